// File: rtl/selector41_rr_arbiter.sv
// Round-robin arbiter sharing one 4:1 WIDTH-bit selector among four requesters.
// Grant, select lines, selected word, valid flag and source index are all
// registered; no combinational path exists from iReq to any output.
module selector41_rr_arbiter #(
   parameter int unsigned WIDTH     = 4,
   parameter int unsigned MAX_BURST = 4
) (
   input  logic             iClk,
   input  logic             iRst,
   input  logic [3:0]       iReq,
   input  logic [WIDTH-1:0] iC0,
   input  logic [WIDTH-1:0] iC1,
   input  logic [WIDTH-1:0] iC2,
   input  logic [WIDTH-1:0] iC3,
   output logic [3:0]       oGnt,
   output logic             oS1,
   output logic             oS0,
   output logic [WIDTH-1:0] oZ,
   output logic             oValid,
   output logic [1:0]       oSrc
);

   typedef enum logic {
      IDLE  = 1'b0,
      GRANT = 1'b1
   } stateT;

   stateT            state;
   logic [1:0]       g;
   logic [1:0]       p;
   logic [3:0]       cnt;

   logic [1:0]       winner;
   logic             found;
   logic [1:0]       scanIdx;
   logic             holderReq;
   logic             othersPending;
   logic             burstDone;
   logic [WIDTH-1:0] selData;

   // Round-robin pick: first set request scanning upward from p+1, wrapping.
   // In GRANT p equals g, so this is also the re-pick order starting at g+1;
   // g is scanned last and therefore never wins while another request is set.
   always_comb begin
      winner  = '0;
      found   = 1'b0;
      scanIdx = '0;
      for (int unsigned i = 0; i < 4; i++) begin
         scanIdx = p + 2'd1 + 2'(i);
         if (!found && iReq[scanIdx]) begin
            winner = scanIdx;
            found  = 1'b1;
         end
      end
   end

   // Holder status and the 4:1 selector driven by the registered grant index.
   always_comb begin
      holderReq     = iReq[g];
      othersPending = |(iReq & ~(4'b0001 << g));
      burstDone     = (cnt == 4'(MAX_BURST));
      case (g)
         2'd0:    selData = iC0;
         2'd1:    selData = iC1;
         2'd2:    selData = iC2;
         default: selData = iC3;
      endcase
   end

   // Arbitration FSM: grant index, last-served pointer, burst counter, grant.
   always_ff @(posedge iClk) begin
      if (iRst) begin
         state <= IDLE;
         g     <= 2'd0;
         p     <= 2'd3;
         cnt   <= '0;
         oGnt  <= '0;
      end else begin
         case (state)
            IDLE: begin
               if (|iReq) begin
                  state <= GRANT;
                  g     <= winner;
                  p     <= winner;
                  cnt   <= 4'd1;
                  oGnt  <= 4'b0001 << winner;
               end
            end
            GRANT: begin
               if (!holderReq && !othersPending) begin
                  state <= IDLE;
                  oGnt  <= '0;
               end else if (!holderReq || (burstDone && othersPending)) begin
                  g     <= winner;
                  p     <= winner;
                  cnt   <= 4'd1;
                  oGnt  <= 4'b0001 << winner;
               end else if (!burstDone) begin
                  cnt   <= cnt + 4'd1;
               end
            end
            default: begin
               state <= IDLE;
               oGnt  <= '0;
            end
         endcase
      end
   end

   // Output word capture: transfer only when the holder is still requesting.
   always_ff @(posedge iClk) begin
      if (iRst) begin
         oZ     <= '0;
         oValid <= 1'b0;
         oSrc   <= 2'd0;
      end else if (state == GRANT && holderReq) begin
         oZ     <= selData;
         oValid <= 1'b1;
         oSrc   <= g;
      end else begin
         oValid <= 1'b0;
      end
   end

   assign oS1 = g[1];
   assign oS0 = g[0];

endmodule

// File: tb/tb_selector41_rr_arbiter.sv
// Directed self-checking bench for selector41_rr_arbiter (WIDTH=4, MAX_BURST=4).
module tb_selector41_rr_arbiter;

   logic       iClk;
   logic       iRst;
   logic [3:0] iReq;
   logic [3:0] iC0, iC1, iC2, iC3;
   logic [3:0] oGnt;
   logic       oS1, oS0;
   logic [3:0] oZ;
   logic       oValid;
   logic [1:0] oSrc;

   int unsigned nAssert = 0;
   int unsigned nFail   = 0;
   logic [3:0]  cData [4];

   selector41_rr_arbiter #(.WIDTH(4), .MAX_BURST(4)) dut (
      .iClk   (iClk),
      .iRst   (iRst),
      .iReq   (iReq),
      .iC0    (iC0),
      .iC1    (iC1),
      .iC2    (iC2),
      .iC3    (iC3),
      .oGnt   (oGnt),
      .oS1    (oS1),
      .oS0    (oS0),
      .oZ     (oZ),
      .oValid (oValid),
      .oSrc   (oSrc)
   );

   initial iClk = 1'b0;
   always #5 iClk = ~iClk;

   task automatic tick();
      @(posedge iClk);
      #1;
   endtask

   task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      nAssert++;
      assert (obs === exp) else begin
         nFail++;
         $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
      end
   endtask

   task automatic checkCleared(input string tag);
      check({tag, ".gnt"},   32'(oGnt),         32'h0);
      check({tag, ".sel"},   32'({oS1, oS0}),   32'h0);
      check({tag, ".z"},     32'(oZ),           32'h0);
      check({tag, ".valid"}, 32'(oValid),       32'h0);
      check({tag, ".src"},   32'(oSrc),         32'h0);
   endtask

   initial begin
      int unsigned expG;
      int unsigned expS;

      cData[0] = 4'h5; cData[1] = 4'h6; cData[2] = 4'hA; cData[3] = 4'hC;
      iC0 = cData[0]; iC1 = cData[1]; iC2 = cData[2]; iC3 = cData[3];

      // Reset held two edges with all requests up
      iRst = 1'b1;
      iReq = 4'b1111;
      tick();
      checkCleared("rst1");
      tick();
      checkCleared("rst2");

      // Release: full contention, 17 edges -> 0x4, 1x4, 2x4, 3x4, 0
      iRst = 1'b0;
      for (int k = 1; k <= 17; k++) begin
         tick();
         expG = 32'((k - 1) / 4 % 4);
         check($sformatf("cont%0d.gnt", k), 32'(oGnt), 32'(4'b0001 << expG));
         check($sformatf("cont%0d.sel", k), 32'({oS1, oS0}), expG);
         if (k == 1) begin
            check("cont1.valid", 32'(oValid), 32'h0);
         end else begin
            expS = 32'((k - 2) / 4 % 4);
            check($sformatf("cont%0d.valid", k), 32'(oValid), 32'h1);
            check($sformatf("cont%0d.src", k), 32'(oSrc), expS);
            check($sformatf("cont%0d.z", k), 32'(oZ), 32'(cData[expS]));
         end
      end

      // Reset, then single request from requester 2
      iRst = 1'b1;
      iReq = 4'b0000;
      tick();
      checkCleared("rst3");
      iRst = 1'b0;
      iReq = 4'b0100;
      tick();                                  // edge 0
      check("single0.gnt", 32'(oGnt), 32'h4);
      check("single0.sel", 32'({oS1, oS0}), 32'h2);
      check("single0.valid", 32'(oValid), 32'h0);
      tick();                                  // edge 1
      check("single1.valid", 32'(oValid), 32'h1);
      check("single1.z", 32'(oZ), 32'hA);
      check("single1.src", 32'(oSrc), 32'h2);
      tick();                                  // edge 2
      check("single2.gnt", 32'(oGnt), 32'h4);
      iReq = 4'b0000;
      tick();                                  // edge 3: grant dropped
      check("single3.gnt", 32'(oGnt), 32'h0);
      check("single3.sel", 32'({oS1, oS0}), 32'h2);
      check("single3.valid", 32'(oValid), 32'h0);
      tick();                                  // edge 4: idle, data held
      check("single4.valid", 32'(oValid), 32'h0);
      check("single4.z", 32'(oZ), 32'hA);
      check("single4.src", 32'(oSrc), 32'h2);
      check("single4.sel", 32'({oS1, oS0}), 32'h2);

      // Early release: p=2, so scan 3,0 -> requester 0 first
      iReq = 4'b0101;
      tick();
      check("early0.gnt", 32'(oGnt), 32'h1);
      tick();
      check("early1.gnt", 32'(oGnt), 32'h1);
      check("early1.valid", 32'(oValid), 32'h1);
      check("early1.z", 32'(oZ), 32'h5);
      iReq = 4'b0100;
      tick();                                  // switch without idle cycle
      check("early2.gnt", 32'(oGnt), 32'h4);
      check("early2.sel", 32'({oS1, oS0}), 32'h2);
      tick();
      check("early3.gnt", 32'(oGnt), 32'h4);
      check("early3.valid", 32'(oValid), 32'h1);
      check("early3.z", 32'(oZ), 32'hA);
      check("early3.src", 32'(oSrc), 32'h2);

      // Solo holder: requester 1 alone for 10 edges
      iReq = 4'b0010;
      for (int k = 0; k < 10; k++) begin
         tick();
         check($sformatf("solo%0d.gnt", k), 32'(oGnt), 32'h2);
      end
      check("solo.src", 32'(oSrc), 32'h1);
      check("solo.z", 32'(oZ), 32'h6);
      iReq = 4'b1010;
      tick();                                  // saturated burst yields to 3
      check("newcomer.gnt", 32'(oGnt), 32'h8);
      check("newcomer.sel", 32'({oS1, oS0}), 32'h3);
      check("newcomer.src", 32'(oSrc), 32'h1);
      tick();
      check("newcomer1.src", 32'(oSrc), 32'h3);
      check("newcomer1.z", 32'(oZ), 32'hC);
      check("newcomer1.valid", 32'(oValid), 32'h1);

      // Reset mid-operation while requester 2 holds the grant
      iReq = 4'b0100;
      tick();
      check("mid.gnt", 32'(oGnt), 32'h4);
      iRst = 1'b1;
      tick();
      checkCleared("midrst");
      iRst = 1'b0;
      iReq = 4'b0101;
      tick();
      check("after.gnt", 32'(oGnt), 32'h1);
      check("after.sel", 32'({oS1, oS0}), 32'h0);
      check("after.valid", 32'(oValid), 32'h0);
      tick();
      check("after1.valid", 32'(oValid), 32'h1);
      check("after1.z", 32'(oZ), 32'h5);
      check("after1.src", 32'(oSrc), 32'h0);

      $display("End of test - %0d assertions evaluated, %0d failures", nAssert, nFail);
      $finish;
   end

endmodule
